// File: rtl/fifo_pin_pkg.sv
// Shared encodings for the FIFO pin driver: FSM states, command kinds and
// bit positions of the multiplexed io_in/io_out pin fields.
package fifo_pin_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT  = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_SETUP = 3'd2;
  localparam state_t ST_HIGH  = 3'd3;
  localparam state_t ST_LOW   = 3'd4;

  typedef enum logic [1:0] {
    CMD_RESET,
    CMD_WRITE,
    CMD_READ
  } cmd_kind_e;

  // io_in field positions; [7:2] carries data when write_en, else the command
  localparam int CLK_BIT  = 0;
  localparam int WEN_BIT  = 1;
  localparam int RSTN_BIT = 2;
  localparam int POP_BIT  = 3;
  localparam int PEEK_LSB = 4;
  localparam int DATA_LSB = 2;

  // io_out field positions (data_out shares DATA_LSB)
  localparam int INV_CLK_BIT = 0;
  localparam int EMPTY_N_BIT = 1;

  // Idle-looking FIFO reply: data 0, empty, inv_clk high (fifo clk low)
  localparam logic [7:0] SYNC_RESET_VAL = 8'b0000_0001;

endpackage

// File: rtl/fifo_pin_sync.sv
// Multi-flop synchroniser for the FIFO's io_out pins; resets to the value an
// idle, empty FIFO would present so no spurious link error is seen.
module fifo_pin_sync
  import fifo_pin_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] raw,
  output logic [7:0] synced
);

  logic [7:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= SYNC_RESET_VAL;
    end else begin
      stage_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign synced = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_pin_driver.sv
// Host-side driver for the 6-bit FIFO's 8-pin multiplexed interface: turns
// write/read/reset requests into clocked pin transactions and decodes replies.
//
// state | meaning
// ------+-----------------------------------------------------------------
// INIT  | first cycle after reset; launches the FIFO reset transaction
// IDLE  | fifo clk low, neutral bus; accepts reset > write > read
// SETUP | command on bus, fifo clk low; last cycle samples the reply
// HIGH  | fifo clk high (FIFO acts on the rising edge); occupancy updated
// LOW   | fifo clk low with bus held; exit returns to IDLE
module fifo_pin_driver
  import fifo_pin_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SETUP_CYC   = 3,
  parameter int HALF_CYC    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic [5:0] wr_data,
  output logic       wr_ready,
  input  logic       rd_valid,
  input  logic [3:0] rd_peek,
  input  logic       rd_pop,
  output logic       rd_ready,
  output logic       rsp_valid,
  output logic [5:0] rsp_data,
  output logic       rsp_empty,
  input  logic       fifo_reset_req,
  output logic [4:0] occupancy,
  output logic       link_err,
  output logic [7:0] io_in_o,
  input  logic [7:0] io_out_i
);

  localparam int CNT_MAX = (SETUP_CYC > HALF_CYC) ? SETUP_CYC : HALF_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [4:0]       OCC_FULL   = 5'(DEPTH);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  cmd_kind_e        cmd_q;
  logic [5:0]       data_q;
  logic [3:0]       peek_q;
  logic             pop_q;
  logic [4:0]       occ_q;
  logic             link_err_q;
  logic             rsp_valid_q;
  logic [5:0]       rsp_data_q;
  logic             rsp_empty_q;

  logic [7:0] io_sync;
  logic [7:0] bus;
  logic       is_idle;
  logic       not_full;
  logic       tc;
  logic       sampled_empty;
  logic       eff_pop;

  fifo_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (io_out_i),
    .synced (io_sync)
  );

  assign is_idle  = (state_q == ST_IDLE);
  assign not_full = (occ_q < OCC_FULL);
  assign wr_ready = reset_n & is_idle & ~fifo_reset_req & not_full;
  assign rd_ready = reset_n & is_idle & ~fifo_reset_req & ~(wr_valid & not_full);

  assign tc            = (cnt_q == '0);
  assign sampled_empty = ~io_sync[EMPTY_N_BIT];
  // A pop against an empty FIFO is dropped so the edge becomes a no-op
  assign eff_pop       = (cmd_q == CMD_READ) & pop_q & ~sampled_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      cmd_q       <= CMD_RESET;
      data_q      <= '0;
      peek_q      <= '0;
      pop_q       <= 1'b0;
      occ_q       <= '0;
      link_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_empty_q <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          cmd_q   <= CMD_RESET;
          peek_q  <= '0;
          pop_q   <= 1'b0;
          cnt_q   <= SETUP_LOAD;
          state_q <= ST_SETUP;
        end
        ST_IDLE: begin
          if (fifo_reset_req) begin
            cmd_q   <= CMD_RESET;
            peek_q  <= '0;
            pop_q   <= 1'b0;
            cnt_q   <= SETUP_LOAD;
            state_q <= ST_SETUP;
          end else if (wr_valid && wr_ready) begin
            cmd_q   <= CMD_WRITE;
            data_q  <= wr_data;
            cnt_q   <= SETUP_LOAD;
            state_q <= ST_SETUP;
          end else if (rd_valid && rd_ready) begin
            cmd_q   <= CMD_READ;
            peek_q  <= rd_peek;
            pop_q   <= rd_pop;
            cnt_q   <= SETUP_LOAD;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tc) begin
            rsp_data_q  <= io_sync[DATA_LSB +: 6];
            rsp_empty_q <= sampled_empty;
            if (!io_sync[INV_CLK_BIT]) link_err_q <= 1'b1;
            if (cmd_q == CMD_READ && sampled_empty) pop_q <= 1'b0;
            case (cmd_q)
              CMD_WRITE: if (not_full) occ_q <= occ_q + 5'd1;
              CMD_READ:  if (eff_pop && occ_q != '0) occ_q <= occ_q - 5'd1;
              default:   occ_q <= '0;
            endcase
            cnt_q   <= HALF_LOAD;
            state_q <= ST_HIGH;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (tc) begin
            cnt_q   <= HALF_LOAD;
            state_q <= ST_LOW;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_LOW: begin
          if (tc) begin
            rsp_valid_q <= (cmd_q == CMD_READ);
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Bus content depends only on the latched command; fifo clk is the state
  always_comb begin
    bus = '0;
    case (state_q)
      ST_IDLE: bus[RSTN_BIT] = 1'b1;
      ST_SETUP, ST_HIGH, ST_LOW: begin
        bus[CLK_BIT] = (state_q == ST_HIGH);
        case (cmd_q)
          CMD_WRITE: begin
            bus[WEN_BIT]          = 1'b1;
            bus[DATA_LSB +: 6]    = data_q;
          end
          CMD_READ: begin
            bus[RSTN_BIT]         = 1'b1;
            bus[POP_BIT]          = pop_q;
            bus[PEEK_LSB +: 4]    = peek_q;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Reset drives the FIFO-reset command at once, without waiting for an edge
  assign io_in_o   = reset_n ? bus : 8'h00;
  assign occupancy = occ_q;
  assign link_err  = link_err_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_empty = rsp_empty_q;

endmodule

// File: tb/tb_fifo_pin_driver.sv
// Scoreboard bench for fifo_pin_driver: a behavioural FIFO on the pin side,
// queued expectations for each fifo-clk edge and each read response.
module tb_fifo_pin_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [5:0] wr_data = '0;
  logic       rd_valid = 1'b0;
  logic [3:0] rd_peek = '0;
  logic       rd_pop = 1'b0;
  logic       fifo_reset_req = 1'b0;
  logic       wr_ready, rd_ready, rsp_valid, rsp_empty, link_err;
  logic [5:0] rsp_data;
  logic [4:0] occupancy;
  logic [7:0] io_in_o;
  logic [7:0] io_out_i;

  int errors = 0;
  int checks = 0;

  logic [6:0] edge_q[$];
  logic [6:0] rsp_q[$];
  logic [6:0] exp_rsp;
  logic [6:0] exp_edge;

  logic [5:0] mem [16];
  int         fcnt = 0;
  logic       prev_fclk = 1'b0;
  logic       tie_inv = 1'b0;

  always #5 clk = ~clk;

  fifo_pin_driver dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_valid      (rd_valid),
    .rd_peek       (rd_peek),
    .rd_pop        (rd_pop),
    .rd_ready      (rd_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_empty     (rsp_empty),
    .fifo_reset_req(fifo_reset_req),
    .occupancy     (occupancy),
    .link_err      (link_err),
    .io_in_o       (io_in_o),
    .io_out_i      (io_out_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake not seen within 100 cycles", name);
  endtask

  // Pin-side FIFO: combinational replies from peek and contents
  always_comb begin
    io_out_i = '0;
    if (int'(io_in_o[7:4]) < fcnt) io_out_i[7:2] = mem[io_in_o[7:4]];
    io_out_i[1] = (fcnt != 0);
    io_out_i[0] = tie_inv ? 1'b0 : ~io_in_o[0];
  end

  // Edge monitor: compare the bus at each fifo-clk rise, then let the FIFO act
  always @(negedge clk) begin
    if (io_in_o[0] && !prev_fclk) begin
      if (edge_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL edge_unexpected: bus 0x%0h seen, no edge expected", io_in_o);
      end else begin
        exp_edge = edge_q.pop_front();
        check("edge_bus", {25'd0, io_in_o[7:1]}, {25'd0, exp_edge});
      end
      if (io_in_o[1]) begin
        if (fcnt < 16) begin
          mem[fcnt] = io_in_o[7:2];
          fcnt++;
        end
      end else if (!io_in_o[2]) begin
        fcnt = 0;
      end else if (io_in_o[3] && fcnt > 0) begin
        for (int i = 0; i < 15; i++) mem[i] = mem[i+1];
        fcnt--;
      end
    end
    prev_fclk = io_in_o[0];
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: data 0x%0h empty %0b, no response expected", rsp_data, rsp_empty);
      end else begin
        exp_rsp = rsp_q.pop_front();
        check("rsp_data", rsp_data, exp_rsp[5:0]);
        check("rsp_empty", rsp_empty, exp_rsp[6]);
      end
    end
  end

  // Leaves the caller at negedge+1 with the DUT in IDLE
  task automatic wait_idle();
    int n = 0;
    @(negedge clk); #1;
    while (!rd_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!rd_ready) timeout("idle_wait");
  endtask

  task automatic do_write(input logic [5:0] d);
    int n = 0;
    edge_q.push_back({d, 1'b1});
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = d;
    #1;
    while (!wr_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!wr_ready) timeout("write_accept");
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] peek, input logic pop, input logic [5:0] exp_data,
                         input logic exp_empty, input logic pop_at_edge);
    int n = 0;
    rsp_q.push_back({exp_empty, exp_data});
    edge_q.push_back({peek, pop_at_edge, 1'b1, 1'b0});
    @(negedge clk);
    rd_valid = 1'b1;
    rd_peek  = peek;
    rd_pop   = pop;
    #1;
    while (!rd_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!rd_ready) timeout("read_accept");
    @(posedge clk); #1;
    rd_valid = 1'b0;
    rd_pop   = 1'b0;
  endtask

  task automatic do_reset_req();
    edge_q.push_back(7'd0);
    wait_idle();
    fifo_reset_req = 1'b1;
    @(posedge clk); #1;
    fifo_reset_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    edge_q.push_back(7'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_io_in", io_in_o, 8'h00);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_ready", rd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 6'h00);
    check("rst_rsp_empty", rsp_empty, 1'b1);
    check("rst_occupancy", occupancy, 5'd0);
    check("rst_link_err", link_err, 1'b0);

    @(negedge clk);
    reset_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("init_not_idle_at_7", wr_ready, 1'b0);
    @(posedge clk);
    #1;
    check("init_idle_at_8", wr_ready, 1'b1);
    check("init_occupancy", occupancy, 5'd0);
    check("idle_bus", io_in_o, 8'h04);

    do_write(6'h15);
    do_write(6'h2A);
    do_write(6'h3F);
    wait_idle();
    check("wr3_occupancy", occupancy, 5'd3);
    check("wr3_model_cnt", fcnt, 3);
    check("wr3_model_0", mem[0], 6'h15);
    check("wr3_model_1", mem[1], 6'h2A);
    check("wr3_model_2", mem[2], 6'h3F);

    do_read(4'd2, 1'b0, 6'h3F, 1'b0, 1'b0);
    wait_idle();
    check("peek2_occupancy", occupancy, 5'd3);
    do_read(4'd0, 1'b1, 6'h15, 1'b0, 1'b1);
    wait_idle();
    check("pop_occupancy", occupancy, 5'd2);
    check("pop_model_cnt", fcnt, 2);

    do_reset_req();
    wait_idle();
    check("rstreq_occupancy", occupancy, 5'd0);
    do_read(4'd0, 1'b1, 6'h00, 1'b1, 1'b0);
    wait_idle();
    check("empty_pop_occupancy", occupancy, 5'd0);

    for (int i = 0; i < 16; i++) do_write(6'(i + 1));
    wait_idle();
    check("full_occupancy", occupancy, 5'd16);
    check("full_wr_ready", wr_ready, 1'b0);
    check("full_model_cnt", fcnt, 16);

    // All three requests at once while full: reset first, then the write
    edge_q.push_back(7'd0);
    edge_q.push_back({6'h09, 1'b1});
    wr_valid = 1'b1;
    wr_data = 6'h09;
    rd_valid = 1'b1;
    rd_peek = 4'd1;
    rd_pop = 1'b1;
    fifo_reset_req = 1'b1;
    @(posedge clk); #1;
    fifo_reset_req = 1'b0;
    rd_valid = 1'b0;
    rd_pop = 1'b0;
    n = 0;
    @(negedge clk); #1;
    while (!wr_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!wr_ready) timeout("race_write_accept");
    check("race_occ_after_reset", occupancy, 5'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wait_idle();
    check("race_occupancy", occupancy, 5'd1);
    check("race_model_0", mem[0], 6'h09);

    tie_inv = 1'b1;
    do_write(6'h22);
    wait_idle();
    check("link_err_set", link_err, 1'b1);
    tie_inv = 1'b0;
    do_write(6'h11);
    wait_idle();
    check("link_err_sticky", link_err, 1'b1);
    check("link_occupancy", occupancy, 5'd3);

    // Abort a write mid-SETUP; the bus must drop to the reset command at once
    wr_valid = 1'b1;
    wr_data = 6'h3C;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_bus", io_in_o, 8'h00);
    edge_q.push_back(7'd0);
    @(posedge clk); #1;
    check("abort_link_err", link_err, 1'b0);
    check("abort_occupancy", occupancy, 5'd0);
    check("abort_wr_ready", wr_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle();
    check("reinit_occupancy", occupancy, 5'd0);
    check("reinit_model_cnt", fcnt, 0);

    repeat (20) @(negedge clk);
    check("edges_outstanding", edge_q.size(), 0);
    check("rsps_outstanding", rsp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
